// File: rtl/interrupt_dispatch.sv
// interrupt_dispatch
//   CPU-side interrupt responder. Priority-encodes pending = IF & IE
//   (bit0 highest), owns the master enable IME with EI/DI/RETI semantics,
//   sequences dispatch with the core (REQ -> PUSH -> JUMP), hands back the
//   restart vector and issues the IF-bit clear. Also produces the HALT wake.
//
//   Optional feature macro: INT_DISPATCH_CANCEL_EN
//     defined   : pending is re-sampled in the PUSH_DONE cycle; if nothing is
//                 pending then, the vector is 16'h0000 and no IF clear issues.
//     undefined : the source latched when the request was raised is final.
//
//   Ports
//     I_CLOCK, I_RESET_L        clock (rising edge), async active-low reset
//     I_IF, I_IE                request flags / enable bits (5 sources)
//     I_EI, I_DI, I_RETI        one-cycle instruction pulses
//     I_INSTR_BOUNDARY, I_HALT  core status
//     I_INT_ACK, I_PUSH_DONE    core handshake strobes
//     O_INT_REQ, O_JUMP, O_VECTOR, O_IF_CLR, O_IF_CLR_LOAD,
//     O_IME, O_WAKE, O_BUSY     dispatch outputs
//
//   state | meaning
//   IDLE  | no dispatch in progress, watching instruction boundaries
//   REQ   | dispatch requested, waiting for core ack
//   PUSH  | core pushing PC, waiting for push done
//   JUMP  | one cycle: vector valid, PC load, IF clear strobe
module interrupt_dispatch #(
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET_L,
  input  logic [4:0]  I_IF,
  input  logic [4:0]  I_IE,
  input  logic        I_EI,
  input  logic        I_DI,
  input  logic        I_RETI,
  input  logic        I_INSTR_BOUNDARY,
  input  logic        I_HALT,
  input  logic        I_INT_ACK,
  input  logic        I_PUSH_DONE,
  output logic        O_INT_REQ,
  output logic        O_JUMP,
  output logic [15:0] O_VECTOR,
  output logic [4:0]  O_IF_CLR,
  output logic        O_IF_CLR_LOAD,
  output logic        O_IME,
  output logic        O_WAKE,
  output logic        O_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PUSH = 2'd2,
    ST_JUMP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ime_q;
  logic        ei_delay_q;
  logic [4:0]  pending;
  logic        dispatch_go;
  logic        busy;
  logic        final_valid;
  logic [2:0]  final_idx;
  logic [15:0] vector_q;
  logic [4:0]  if_clr_q;
  logic        if_clr_load_q;

  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] vec_of(input logic [2:0] idx);
    return VEC_BASE + 16'(VEC_STRIDE) * {13'd0, idx};
  endfunction

  assign pending     = I_IF & I_IE;
  // Uses the registered IME, so the boundary that promotes a delayed EI
  // cannot itself dispatch.
  assign dispatch_go = I_INSTR_BOUNDARY & ime_q & (|pending);
  assign busy        = (state_q == ST_REQ) || (state_q == ST_PUSH);

`ifdef INT_DISPATCH_CANCEL_EN
  assign final_valid = |pending;
  assign final_idx   = lowest_idx(pending);
`else
  logic [2:0] idx_q;

  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      idx_q <= 3'd0;
    end else if (state_q == ST_IDLE && dispatch_go) begin
      idx_q <= lowest_idx(pending);
    end
  end

  assign final_valid = 1'b1;
  assign final_idx   = idx_q;
`endif

  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dispatch_go) state_d = ST_REQ;
      ST_REQ:  if (I_INT_ACK) state_d = ST_PUSH;
      ST_PUSH: if (I_PUSH_DONE) state_d = ST_JUMP;
      ST_JUMP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // IME / delayed-EI. Ack always wins; DI beats EI and RETI; pulses that
  // arrive while the sequence is busy are dropped.
  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      ime_q      <= 1'b0;
      ei_delay_q <= 1'b0;
    end else if (state_q == ST_REQ && I_INT_ACK) begin
      ime_q <= 1'b0;
    end else if (!busy) begin
      if (I_DI) begin
        ime_q      <= 1'b0;
        ei_delay_q <= 1'b0;
      end else begin
        if (I_RETI || (I_INSTR_BOUNDARY && ei_delay_q)) ime_q <= 1'b1;
        if (I_INSTR_BOUNDARY && ei_delay_q) ei_delay_q <= 1'b0;
        if (I_EI) ei_delay_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      vector_q      <= 16'h0000;
      if_clr_q      <= 5'b00000;
      if_clr_load_q <= 1'b0;
    end else if (state_q == ST_PUSH && I_PUSH_DONE) begin
      if (final_valid) begin
        vector_q      <= vec_of(final_idx);
        if_clr_q      <= 5'b00001 << final_idx;
        if_clr_load_q <= 1'b1;
      end else begin
        vector_q      <= 16'h0000;
        if_clr_q      <= 5'b00000;
        if_clr_load_q <= 1'b0;
      end
    end else begin
      if_clr_load_q <= 1'b0;
    end
  end

  assign O_INT_REQ     = (state_q == ST_REQ);
  assign O_BUSY        = busy;
  assign O_JUMP        = (state_q == ST_JUMP);
  assign O_VECTOR      = vector_q;
  assign O_IF_CLR      = if_clr_q;
  assign O_IF_CLR_LOAD = if_clr_load_q;
  assign O_IME         = ime_q;
  assign O_WAKE        = I_HALT & (|pending);

endmodule

// File: tb/tb_interrupt_dispatch.sv
module tb_interrupt_dispatch;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET_L;
  logic [4:0]  I_IF, I_IE;
  logic        I_EI, I_DI, I_RETI, I_INSTR_BOUNDARY, I_HALT, I_INT_ACK, I_PUSH_DONE;
  logic        O_INT_REQ, O_JUMP, O_IF_CLR_LOAD, O_IME, O_WAKE, O_BUSY;
  logic [15:0] O_VECTOR;
  logic [4:0]  O_IF_CLR;

  interrupt_dispatch dut (
    .I_CLOCK(I_CLOCK), .I_RESET_L(I_RESET_L), .I_IF(I_IF), .I_IE(I_IE),
    .I_EI(I_EI), .I_DI(I_DI), .I_RETI(I_RETI), .I_INSTR_BOUNDARY(I_INSTR_BOUNDARY),
    .I_HALT(I_HALT), .I_INT_ACK(I_INT_ACK), .I_PUSH_DONE(I_PUSH_DONE),
    .O_INT_REQ(O_INT_REQ), .O_JUMP(O_JUMP), .O_VECTOR(O_VECTOR), .O_IF_CLR(O_IF_CLR),
    .O_IF_CLR_LOAD(O_IF_CLR_LOAD), .O_IME(O_IME), .O_WAKE(O_WAKE), .O_BUSY(O_BUSY)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  int n_cmp = 0;
  int n_err = 0;

  localparam int PH_IDLE = 0, PH_REQ = 1, PH_PUSH = 2, PH_JUMP = 3;

  // Reference model: sequence phase, IME, pending EI, and the dispatch result.
  int          m_phase;
  logic        m_ime, m_eid, m_load;
  int          m_src;
  logic [15:0] m_vec;
  logic [4:0]  m_clr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Highest-priority source: isolate lowest set bit, count the ones below it.
  function automatic int first_src(input logic [4:0] p);
    logic [4:0] iso, below;
    iso   = p & (~p + 5'd1);
    below = iso - 5'd1;
    return $countones(below);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_ime = 1'b0; m_eid = 1'b0; m_load = 1'b0;
    m_src = 0; m_vec = 16'h0000; m_clr = 5'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},  O_INT_REQ, 0);
    check({tag, "_jump"}, O_JUMP, 0);
    check({tag, "_vec"},  O_VECTOR, 0);
    check({tag, "_clr"},  O_IF_CLR, 0);
    check({tag, "_load"}, O_IF_CLR_LOAD, 0);
    check({tag, "_ime"},  O_IME, 0);
    check({tag, "_busy"}, O_BUSY, 0);
  endtask

  // One clock: drive inputs, check comb wake, advance model, check after edge.
  task automatic cycle(input logic [4:0] f, input logic [4:0] e, input logic bnd,
                       input logic ei, input logic di, input logic reti,
                       input logic halt, input logic ack, input logic done);
    logic [4:0] pend;
    int nphase;
    logic busy_now;
    I_IF = f; I_IE = e; I_INSTR_BOUNDARY = bnd; I_EI = ei; I_DI = di; I_RETI = reti;
    I_HALT = halt; I_INT_ACK = ack; I_PUSH_DONE = done;
    #1;
    pend = f & e;
    check("wake", O_WAKE, (halt && pend != 0) ? 1 : 0);
    busy_now = (m_phase == PH_REQ) || (m_phase == PH_PUSH);
    nphase = m_phase;
    case (m_phase)
      PH_IDLE: if (bnd && m_ime && pend != 0) begin
        nphase = PH_REQ;
        m_src  = first_src(pend);
      end
      PH_REQ: if (ack) nphase = PH_PUSH;
      PH_PUSH: if (done) begin
        nphase = PH_JUMP;
`ifdef INT_DISPATCH_CANCEL_EN
        if (pend == 0) begin
          m_load = 1'b0; m_vec = 16'h0000;
        end else begin
          m_load = 1'b1;
          m_vec  = 16'h0040 + 16'(8 * first_src(pend));
          m_clr  = 5'(1 << first_src(pend));
        end
`else
        m_load = 1'b1;
        m_vec  = 16'h0040 + 16'(8 * m_src);
        m_clr  = 5'(1 << m_src);
`endif
      end
      default: nphase = PH_IDLE;
    endcase
    if (m_phase == PH_REQ && ack) m_ime = 1'b0;
    else if (!busy_now) begin
      if (di) begin
        m_ime = 1'b0; m_eid = 1'b0;
      end else begin
        if (bnd && m_eid) begin m_ime = 1'b1; m_eid = 1'b0; end
        if (reti) m_ime = 1'b1;
        if (ei) m_eid = 1'b1;
      end
    end
    m_phase = nphase;
    @(posedge I_CLOCK); #1;
    check("int_req", O_INT_REQ, (m_phase == PH_REQ) ? 1 : 0);
    check("busy", O_BUSY, (m_phase == PH_REQ || m_phase == PH_PUSH) ? 1 : 0);
    check("jump", O_JUMP, (m_phase == PH_JUMP) ? 1 : 0);
    check("ime", O_IME, m_ime);
    check("clr_load", O_IF_CLR_LOAD, (m_phase == PH_JUMP && m_load) ? 1 : 0);
    if (m_phase == PH_JUMP) begin
      check("vector", O_VECTOR, m_vec);
      if (m_load) check("if_clr", O_IF_CLR, m_clr);
    end
  endtask

  task automatic idle(input logic [4:0] f, input logic [4:0] e, input logic bnd);
    cycle(f, e, bnd, 0, 0, 0, 0, 0, 0);
  endtask

  logic [4:0] rf, re;

  initial begin
    I_RESET_L = 1'b0;
    I_IF = 0; I_IE = 0; I_EI = 0; I_DI = 0; I_RETI = 0;
    I_INSTR_BOUNDARY = 0; I_HALT = 0; I_INT_ACK = 0; I_PUSH_DONE = 0;
    model_reset();
    #12;
    check_zero("por");
    @(posedge I_CLOCK); #1;
    I_RESET_L = 1'b1;

    // RETI alone enables immediately
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("reti_ime", O_IME, 1);

    // Two pending, lower index wins: TIMER (bit2) -> 0x0050
    idle(5'b10100, 5'b11111, 1);
    check("prio_req", O_INT_REQ, 1);
    cycle(5'b10100, 5'b11111, 1, 0, 0, 0, 0, 1, 0);
    cycle(5'b10100, 5'b11111, 1, 0, 0, 0, 0, 0, 1);
    check("prio_vec", O_VECTOR, 16'h0050);
    check("prio_clr", O_IF_CLR, 5'b00100);
    check("prio_ime", O_IME, 0);
    idle(0, 0, 0);

    // EI delays IME by one boundary
    cycle(5'b00001, 5'b00001, 0, 1, 0, 0, 0, 0, 0);
    idle(5'b00001, 5'b00001, 1);
    check("ei_noreq", O_INT_REQ, 0);
    check("ei_ime", O_IME, 1);
    idle(5'b00001, 5'b00001, 1);
    check("ei_req", O_INT_REQ, 1);
    cycle(5'b00001, 5'b00001, 1, 0, 0, 0, 0, 1, 0);
    cycle(5'b00001, 5'b00001, 0, 0, 0, 0, 0, 0, 1);
    check("ei_vec", O_VECTOR, 16'h0040);
    idle(0, 0, 0);

    // EI and DI together: DI wins, nothing dispatches
    cycle(5'b00001, 5'b00001, 0, 1, 1, 0, 0, 0, 0);
    check("eidi_ime", O_IME, 0);
    for (int i = 0; i < 3; i++) begin
      idle(5'b00001, 5'b00001, 1);
      check("eidi_noreq", O_INT_REQ, 0);
    end
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("reti2_ime", O_IME, 1);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);

    // HALT wake with IME off
    cycle(5'b10000, 5'b10000, 1, 0, 0, 0, 1, 0, 0);
    check("halt_noreq", O_INT_REQ, 0);
    I_HALT = 1'b1; #1;
    check("halt_wake", O_WAKE, 1);

    // Cancel: JOYPAD flag drops during PUSH
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(5'b10000, 5'b10000, 1);
    cycle(5'b10000, 5'b10000, 1, 0, 0, 0, 0, 1, 0);
    cycle(5'b00000, 5'b10000, 0, 0, 0, 0, 0, 0, 1);
`ifdef INT_DISPATCH_CANCEL_EN
    check("cancel_vec", O_VECTOR, 16'h0000);
    check("cancel_load", O_IF_CLR_LOAD, 0);
`else
    check("cancel_vec", O_VECTOR, 16'h0060);
    check("cancel_clr", O_IF_CLR, 5'b10000);
    check("cancel_load", O_IF_CLR_LOAD, 1);
`endif
    idle(0, 0, 0);
    check("cancel_ime", O_IME, 0);

    // Reset in the middle of PUSH
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(5'b00010, 5'b00010, 1);
    cycle(5'b00010, 5'b00010, 1, 0, 0, 0, 0, 1, 0);
    check("mid_busy", O_BUSY, 1);
    I_RESET_L = 1'b0; #1;
    model_reset();
    check_zero("rst_async");
    @(posedge I_CLOCK); #1;
    check_zero("rst_held");
    I_RESET_L = 1'b1;
    idle(5'b00010, 5'b00010, 0);
    check("rst_noload", O_IF_CLR_LOAD, 0);

    // Randomized core-like traffic
    rf = 5'($urandom); re = 5'($urandom);
    for (int k = 0; k < 3000; k++) begin
      logic bnd, ei, di, reti, ack, done;
      int r;
      if ($urandom_range(0, 5) == 0) rf = 5'($urandom);
      if ($urandom_range(0, 9) == 0) re = 5'($urandom);
      bnd = 1'($urandom_range(0, 1));
      ei = 0; di = 0; reti = 0;
      if (!bnd && m_phase != PH_JUMP) begin
        r = $urandom_range(0, 11);
        case (r)
          0: ei = 1;
          1: di = 1;
          2, 3: reti = 1;
          4: begin ei = 1; di = 1; end
          5: begin reti = 1; di = 1; end
          6: begin ei = 1; reti = 1; end
          default: ;
        endcase
      end
      ack  = (m_phase == PH_REQ) && ($urandom_range(0, 2) == 0);
      done = (m_phase == PH_REQ || m_phase == PH_PUSH) && ($urandom_range(0, 2) == 0);
      cycle(rf, re, bnd, ei, di, reti, 1'($urandom_range(0, 1)), ack, done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_dispatch.md
# interrupt_dispatch

CPU-side responder for the interrupt request/enable registers: consumes the IF and IE bit vectors, owns the master enable (IME) with EI/DI/RETI semantics, and sequences interrupt service with the CPU core. It priority-encodes pending sources, hands the core a restart vector, and issues the IF-bit clear back to the register file. It also generates the HALT wake signal.

## Interface
Parameters:
- VEC_BASE, 16'h0040, vector of source 0; source n vectors to VEC_BASE + 8*n
- VEC_STRIDE, 8, byte spacing between vectors

Ports:
- I_CLOCK  in  1  system clock, rising edge
- I_RESET_L  in  1  asynchronous, active-low reset
- I_IF  in  5  interrupt request flags (bit0 VBLANK … bit4 JOYPAD)
- I_IE  in  5  interrupt enable bits
- I_EI  in  1  one-cycle pulse: EI executed
- I_DI  in  1  one-cycle pulse: DI executed
- I_RETI  in  1  one-cycle pulse: RETI executed
- I_INSTR_BOUNDARY  in  1  core is between instructions, fetch not yet committed
- I_HALT  in  1  core is halted (level)
- I_INT_ACK  in  1  core accepts dispatch, begins PC push
- I_PUSH_DONE  in  1  core finished pushing PC
- O_INT_REQ  out  1  dispatch requested; core must not fetch
- O_JUMP  out  1  one-cycle pulse: load PC from O_VECTOR
- O_VECTOR  out  16  restart address
- O_IF_CLR  out  5  one-hot IF bit to clear
- O_IF_CLR_LOAD  out  1  one-cycle strobe qualifying O_IF_CLR
- O_IME  out  1  master interrupt enable
- O_WAKE  out  1  pending interrupt while halted
- O_BUSY  out  1  dispatch sequence in progress

## Operation
- pending = I_IF & I_IE; index = lowest set bit (bit0 highest priority).
- States: IDLE, REQ, PUSH, JUMP.
- IDLE -> REQ on edge where I_INSTR_BOUNDARY & O_IME & |pending; index latched.
- REQ: O_INT_REQ=1, O_BUSY=1; held until I_INT_ACK. On ack edge: IME<=0, -> PUSH.
- PUSH: O_BUSY=1; waits for I_PUSH_DONE, -> JUMP.
- JUMP: single cycle, O_JUMP=1, O_VECTOR valid, -> IDLE.
- EI: sets ei_delay. At first edge with I_INSTR_BOUNDARY & ei_delay: IME<=1, ei_delay<=0. That boundary's dispatch check uses old IME (0), so exactly one instruction runs after EI before dispatch.
- DI: IME<=0, ei_delay<=0 at that edge. DI wins over simultaneous EI or RETI.
- RETI: IME<=1 at that edge (no delay).
- EI/DI/RETI pulses while O_BUSY are ignored.
- O_WAKE = I_HALT & |pending, combinational, independent of IME.
- O_VECTOR = VEC_BASE + VEC_STRIDE*index, registered; 16'h0000 when cancelled (see Configuration).

## Timing
- Reset (async, I_RESET_L=0): state IDLE, IME=0, ei_delay=0, O_INT_REQ=0, O_JUMP=0, O_VECTOR=0, O_IF_CLR=0, O_IF_CLR_LOAD=0, O_BUSY=0. O_WAKE follows inputs. Reset mid-sequence aborts with no IF clear.
- Boundary cycle N qualifying -> O_INT_REQ high from N+1. The core holds at boundary and samples O_INT_REQ in N+1 before fetch.
- Ack in cycle A -> O_IME low from A+1.
- I_PUSH_DONE in cycle P -> O_JUMP, O_VECTOR, O_IF_CLR_LOAD in P+1.
- Minimum sequence: boundary → REQ (1) → PUSH (≥1) → JUMP (1).
- O_IF_CLR_LOAD is asserted only in JUMP and only for a non-cancelled dispatch.
- ACK and PUSH_DONE in the same cycle: PUSH_DONE is ignored; PUSH waits for a later strobe.

## Configuration
- INT_DISPATCH_CANCEL_EN defined: pending is re-evaluated in the PUSH_DONE cycle, and the index and IF clear use that fresh value. If pending==0: O_VECTOR=16'h0000, no O_IF_CLR_LOAD, IME stays 0.
- Undefined: the index latched at IDLE→REQ is final. The vector and IF clear use it even if the flag dropped.

## Test plan
- Reset low mid-PUSH -> all outputs 0, O_IME=0, next cycle IDLE; no O_IF_CLR_LOAD.
- IME=1, I_IF=5'b10100, I_IE=5'b11111, boundary -> O_INT_REQ next cycle. After ack and done: O_VECTOR=16'h0050, O_IF_CLR=5'b00100, O_IME=0.
- I_EI, then boundary with pending VBLANK -> no request at that boundary. Next boundary -> O_INT_REQ=1, O_VECTOR=16'h0040.
- I_EI and I_DI same cycle -> O_IME stays 0, no dispatch at subsequent boundaries. I_RETI alone -> O_IME=1 next cycle.
- I_HALT=1, IME=0, I_IF=I_IE=5'b10000 -> O_WAKE=1, O_INT_REQ stays 0.
- Cancel test, JOYPAD pending: clear I_IF during PUSH. With INT_DISPATCH_CANCEL_EN -> O_VECTOR=16'h0000, no clear strobe. Without the macro -> O_VECTOR=16'h0060, O_IF_CLR=5'b10000.
